// File: rtl/jedro_1_lsu.sv
// jedro_1 load/store unit: one outstanding access, byte-lane store strobes, aligned/extended load return.
// Optional: define JEDRO_1_LSU_ERR_ADDR_EN to add err_addr_o capturing the last misaligned address.
module jedro_1_lsu #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      ctrl_valid_i,
  input  logic                      ctrl_we_i,
  input  logic [1:0]                ctrl_size_i,
  input  logic                      ctrl_unsigned_i,
  input  logic [ADDR_WIDTH-1:0]     addr_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  input  logic [REG_ADDR_WIDTH-1:0] regdest_i,
  output logic                      ready_o,
  output logic [DATA_WIDTH-1:0]     rdata_o,
  output logic                      rdata_valid_o,
  output logic [REG_ADDR_WIDTH-1:0] regdest_o,
  output logic                      misaligned_load_o,
  output logic                      misaligned_store_o,
  output logic                      mem_en_o,
  output logic [DATA_WIDTH/8-1:0]   mem_we_o,
  output logic [ADDR_WIDTH-1:0]     mem_addr_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i
`ifdef JEDRO_1_LSU_ERR_ADDR_EN
  ,
  output logic [ADDR_WIDTH-1:0]     err_addr_o
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, LOAD_RESP} state_t;

  state_t                      r_state, w_next;
  logic                        w_aligned, w_accept, w_load_go;
  logic [1:0]                  r_off, r_size;
  logic                        r_uns;
  logic [REG_ADDR_WIDTH-1:0]   r_rd, r_regdest;
  logic [DATA_WIDTH-1:0]       r_rdata, w_shifted, w_ext;
  logic                        r_rvalid, r_mis_load, r_mis_store;

  always_comb begin
    case (ctrl_size_i)
      2'b00:   w_aligned = 1'b1;
      2'b01:   w_aligned = ~addr_i[0];
      default: w_aligned = (addr_i[1:0] == 2'b00);
    endcase
  end

  assign ready_o    = (r_state == IDLE) && !rst_i;
  assign w_accept   = ctrl_valid_i && ready_o;
  assign mem_en_o   = w_accept && w_aligned;
  assign w_load_go  = mem_en_o && !ctrl_we_i;
  assign mem_addr_o = {addr_i[ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    mem_we_o    = '0;
    mem_wdata_o = '0;
    if (mem_en_o && ctrl_we_i) begin
      case (ctrl_size_i)
        2'b00: begin
          mem_we_o    = 4'b0001 << addr_i[1:0];
          mem_wdata_o = {4{wdata_i[7:0]}};
        end
        2'b01: begin
          mem_we_o    = 4'b0011 << {addr_i[1], 1'b0};
          mem_wdata_o = {2{wdata_i[15:0]}};
        end
        default: begin
          mem_we_o    = 4'b1111;
          mem_wdata_o = wdata_i;
        end
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (w_load_go) w_next = LOAD_WAIT;
      LOAD_WAIT: w_next = LOAD_RESP;
      LOAD_RESP: w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Half-word offsets are always 0 or 2, so one shift serves both byte and half selection.
  assign w_shifted = mem_rdata_i >> {r_off, 3'b000};

  always_comb begin
    case (r_size)
      2'b00:   w_ext = {{24{~r_uns & w_shifted[7]}}, w_shifted[7:0]};
      2'b01:   w_ext = {{16{~r_uns & w_shifted[15]}}, w_shifted[15:0]};
      default: w_ext = mem_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_off       <= '0;
      r_size      <= '0;
      r_uns       <= 1'b0;
      r_rd        <= '0;
      r_rdata     <= '0;
      r_regdest   <= '0;
      r_rvalid    <= 1'b0;
      r_mis_load  <= 1'b0;
      r_mis_store <= 1'b0;
    end else begin
      r_mis_load  <= w_accept && !w_aligned && !ctrl_we_i;
      r_mis_store <= w_accept && !w_aligned && ctrl_we_i;
      r_rvalid    <= (r_state == LOAD_WAIT);
      if (w_load_go) begin
        r_off  <= addr_i[1:0];
        r_size <= ctrl_size_i;
        r_uns  <= ctrl_unsigned_i;
        r_rd   <= regdest_i;
      end
      if (r_state == LOAD_WAIT) begin
        r_rdata   <= w_ext;
        r_regdest <= r_rd;
      end
    end
  end

`ifdef JEDRO_1_LSU_ERR_ADDR_EN
  logic [ADDR_WIDTH-1:0] r_err_addr;
  always_ff @(posedge clk_i) begin
    if (rst_i)                       r_err_addr <= '0;
    else if (w_accept && !w_aligned) r_err_addr <= addr_i;
  end
  assign err_addr_o = r_err_addr;
`endif

  assign rdata_o            = r_rdata;
  assign rdata_valid_o      = r_rvalid;
  assign regdest_o          = r_regdest;
  assign misaligned_load_o  = r_mis_load;
  assign misaligned_store_o = r_mis_store;

endmodule

// File: tb/tb_jedro_1_lsu.sv
// Self-checking bench for jedro_1_lsu: byte-addressed reference model, word RAM environment, random + directed traffic.
module tb_jedro_1_lsu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0, we = 1'b0, uns = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0, wdata = '0;
  logic [4:0]  rd = '0;
  logic        ready, rvalid, mis_l, mis_s, mem_en;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [4:0]  regdest;
  logic [3:0]  mem_we;
`ifdef JEDRO_1_LSU_ERR_ADDR_EN
  logic [31:0] err_addr;
`endif

  always #5 clk = ~clk;

  jedro_1_lsu dut (
    .clk_i(clk), .rst_i(rst), .ctrl_valid_i(valid), .ctrl_we_i(we), .ctrl_size_i(size),
    .ctrl_unsigned_i(uns), .addr_i(addr), .wdata_i(wdata), .regdest_i(rd),
    .ready_o(ready), .rdata_o(rdata), .rdata_valid_o(rvalid), .regdest_o(regdest),
    .misaligned_load_o(mis_l), .misaligned_store_o(mis_s), .mem_en_o(mem_en),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
`ifdef JEDRO_1_LSU_ERR_ADDR_EN
    , .err_addr_o(err_addr)
`endif
  );

  int n_chk = 0, n_err = 0;
  bit chk_on = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // RAM environment: 64 words, driven purely by the DUT's memory port; reloaded on reset.
  logic [31:0] ram_init [64];
  logic [31:0] ram [64];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) ram[i] <= ram_init[i];
    end else if (mem_en) begin
      for (int i = 0; i < 4; i++)
        if (mem_we[i]) ram[mem_addr[7:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
      if (mem_we == 4'b0000) mem_rdata <= ram[mem_addr[7:2]];
    end
  end

  // Reference model: byte-addressed memory, countdown for the outstanding load.
  logic [7:0]  ref_b [256];
  int          m_wait = 0;
  logic [31:0] pend = '0, e_rdata = '0, e_err = '0;
  logic [4:0]  pend_rd = '0, e_rd = '0;
  logic        e_rvalid = 0, e_mis_l = 0, e_mis_s = 0;

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] s, input logic u);
    logic [31:0] v = 0;
    int nb = nbytes(s);
    for (int k = 0; k < nb; k++) v = v | (32'(ref_b[(a + k) & 255]) << (8 * k));
    if (nb == 1 && !u && v[7])  v = v | 32'hFFFFFF00;
    if (nb == 2 && !u && v[15]) v = v | 32'hFFFF0000;
    return v;
  endfunction

  always @(posedge clk) begin
    bit acc, al;
    int nb;
    if (rst) begin
      m_wait = 0; e_rvalid = 0; e_rdata = 0; e_rd = 0; e_mis_l = 0; e_mis_s = 0; e_err = 0;
      for (int i = 0; i < 256; i++) ref_b[i] = 8'(ram_init[i / 4] >> (8 * (i % 4)));
    end else begin
      nb  = nbytes(size);
      acc = valid && (m_wait == 0);
      al  = (addr % nb) == 0;
      e_mis_l = acc && !al && !we;
      e_mis_s = acc && !al && we;
      if (acc && !al) e_err = addr;
      e_rvalid = 0;
      if (m_wait == 2) begin e_rvalid = 1; e_rdata = pend; e_rd = pend_rd; end
      if (m_wait > 0) m_wait--;
      if (acc && al) begin
        if (we) for (int k = 0; k < nb; k++) ref_b[(addr + k) & 255] = 8'(wdata >> (8 * k));
        else begin pend = ref_load(addr, size, uns); pend_rd = rd; m_wait = 2; end
      end
    end
  end

  // Compare process: every cycle, away from the rising edge.
  always @(negedge clk) begin
    logic        e_ready, e_en;
    logic [3:0]  e_we;
    logic [31:0] e_wd;
    int          nb, msk;
    #2;
    if (chk_on) begin
      nb      = nbytes(size);
      e_ready = (m_wait == 0) && !rst;
      e_en    = valid && e_ready && ((addr % nb) == 0);
      msk     = ((1 << nb) - 1) << addr[1:0];
      e_we    = (e_en && we) ? msk[3:0] : 4'b0000;
      e_wd    = 0;
      if (e_en && we) e_wd = (nb == 1) ? wdata[7:0] * 32'h01010101 :
                             (nb == 2) ? wdata[15:0] * 32'h00010001 : wdata;
      chk("ready_o", 32'(ready), 32'(e_ready));
      chk("mem_en_o", 32'(mem_en), 32'(e_en));
      chk("mem_we_o", 32'(mem_we), 32'(e_we));
      chk("mem_wdata_o", mem_wdata, e_wd);
      chk("mem_addr_o", mem_addr, addr & 32'hFFFFFFFC);
      chk("rdata_valid_o", 32'(rvalid), 32'(e_rvalid));
      chk("rdata_o", rdata, e_rdata);
      chk("regdest_o", 32'(regdest), 32'(e_rd));
      chk("misaligned_load_o", 32'(mis_l), 32'(e_mis_l));
      chk("misaligned_store_o", 32'(mis_s), 32'(e_mis_s));
`ifdef JEDRO_1_LSU_ERR_ADDR_EN
      chk("err_addr_o", err_addr, e_err);
`endif
    end
  end

  logic        s_en, s_ready;
  logic [3:0]  s_we;
  logic [31:0] s_wd, s_addr;

  // Presents a request at the falling edge and holds it until a rising edge accepts it.
  task automatic issue(input logic w, input logic [1:0] s, input logic u, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] r);
    int  g = 0;
    logic acc;
    @(negedge clk);
    valid = 1; we = w; size = s; uns = u; addr = a; wdata = d; rd = r;
    forever begin
      #1;
      acc = ready; s_en = mem_en; s_we = mem_we; s_wd = mem_wdata; s_addr = mem_addr; s_ready = ready;
      @(posedge clk);
      if (acc) break;
      g++;
      if (g > 10) begin
        n_chk++; n_err++;
        $display("FAIL accept_timeout: ready_o never rose for addr %h", a);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    valid = 0; we = 1'($urandom); size = 2'($urandom); addr = $urandom; wdata = $urandom;
  endtask

  task automatic load_lit(input string nm, input logic [1:0] s, input logic u, input logic [31:0] a,
                          input logic [4:0] r, input logic [31:0] exp);
    issue(1'b0, s, u, a, 32'h0, r);
    @(negedge clk); valid = 0;
    @(negedge clk); #2;
    chk({nm, "_valid"}, 32'(rvalid), 32'd1);
    chk({nm, "_data"}, rdata, exp);
    chk({nm, "_rd"}, 32'(regdest), 32'(r));
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ram_init[i] = $urandom;
    ram_init[16] = 32'h0000FFFF;
    ram_init[17] = 32'h0F0F0000;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("ready_in_reset", 32'(ready), 32'd0);
    chk_on = 1;
    rst = 0; #1;
    chk("ready_after_reset", 32'(ready), 32'd1);
    chk("rdata_reset", rdata, 32'd0);
    chk("regdest_reset", 32'(regdest), 32'd0);
    chk("misl_reset", 32'(mis_l), 32'd0);

    load_lit("lh_40", 2'b01, 1'b0, 32'h40, 5'd30, 32'hFFFFFFFF);
    load_lit("lhu_40", 2'b01, 1'b1, 32'h40, 5'd3, 32'h0000FFFF);
    load_lit("lbu_41", 2'b00, 1'b1, 32'h41, 5'd4, 32'h000000FF);
    load_lit("lb_41", 2'b00, 1'b0, 32'h41, 5'd5, 32'hFFFFFFFF);
    load_lit("lh_46", 2'b01, 1'b0, 32'h46, 5'd6, 32'h00000F0F);
    load_lit("lb_47", 2'b00, 1'b0, 32'h47, 5'd7, 32'h0000000F);

    issue(1'b1, 2'b01, 1'b0, 32'h102, 32'h1234ABCD, 5'd0);
    chk("sh_we", 32'(s_we), 32'hC);
    chk("sh_addr", s_addr, 32'h100);
    chk("sh_wdata", s_wd, 32'hABCDABCD);
    issue(1'b1, 2'b00, 1'b0, 32'h101, 32'h55, 5'd0);
    chk("sb_we", 32'(s_we), 32'h2);
    chk("sb_b2b_ready", 32'(s_ready), 32'd1);
    idle();

    issue(1'b0, 2'b01, 1'b0, 32'h41, 32'h0, 5'd9);
    chk("mis_lh_en", 32'(s_en), 32'd0);
    @(negedge clk); valid = 0; #2;
    chk("mis_lh_pulse", 32'(mis_l), 32'd1);
`ifdef JEDRO_1_LSU_ERR_ADDR_EN
    chk("mis_lh_err_addr", err_addr, 32'h41);
`endif
    issue(1'b1, 2'b10, 1'b0, 32'h102, 32'hDEADBEEF, 5'd0);
    chk("mis_sw_we", 32'(s_we), 32'h0);
    @(negedge clk); valid = 0; #2;
    chk("mis_sw_pulse", 32'(mis_s), 32'd1);

    issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 5'd11);
    @(negedge clk); valid = 0; rst = 1;
    @(negedge clk); rst = 0; #2;
    chk("rst_mid_no_valid", 32'(rvalid), 32'd0);
    chk("rst_mid_ready", 32'(ready), 32'd1);
    load_lit("lw_44_after_rst", 2'b10, 1'b0, 32'h44, 5'd12, 32'h0F0F0000);

    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 3) == 0) idle();
      else issue(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom));
    end
    repeat (4) idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/jedro_1_lsu.md
Name: jedro_1_lsu

Overview:
Load/store unit between the jedro_1 decode/execute stage and the byte-writable data RAM. It accepts one memory operation at a time and drives RAM address, enable and byte-write strobes. For loads it aligns the returned word and sign- or zero-extends it for register writeback. Misaligned accesses are flagged and never reach memory.

Parameters:
DATA_WIDTH, 32, data bus width; only 32 is supported.
ADDR_WIDTH, 32, byte address width.
REG_ADDR_WIDTH, 5, destination register index width.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_i  in  1  synchronous reset, active-high.
ctrl_valid_i  in  1  operation request, sampled when ready_o=1.
ctrl_we_i  in  1  1=store, 0=load.
ctrl_size_i  in  2  00=byte, 01=half, 10=word; 11 is reserved and treated as word.
ctrl_unsigned_i  in  1  1=zero-extend load result (lbu/lhu); ignored for stores.
addr_i  in  ADDR_WIDTH  byte address.
wdata_i  in  DATA_WIDTH  store data, in the low bits.
regdest_i  in  REG_ADDR_WIDTH  load destination register.
ready_o  out  1  unit can accept a request this cycle.
rdata_o  out  DATA_WIDTH  extended load result.
rdata_valid_o  out  1  one-cycle pulse; rdata_o and regdest_o are valid.
regdest_o  out  REG_ADDR_WIDTH  destination of the completed load.
misaligned_load_o  out  1  one-cycle pulse for a misaligned load.
misaligned_store_o  out  1  one-cycle pulse for a misaligned store.
mem_en_o  out  1  RAM enable.
mem_we_o  out  DATA_WIDTH/8  byte write strobes.
mem_addr_o  out  ADDR_WIDTH  word-aligned address (addr_i with bits[1:0] forced to 0).
mem_wdata_o  out  DATA_WIDTH  store data, replicated across byte lanes.
mem_rdata_i  in  DATA_WIDTH  RAM read data, valid one cycle after mem_en_o.

Behaviour:
- Reset values: rdata_o=0, rdata_valid_o=0, regdest_o=0, misaligned_*_o=0, state=IDLE.
- Reset values (continued): ready_o=1 the cycle after rst_i is deasserted; ready_o=0 while rst_i=1.
- Handshake: a request is accepted when ctrl_valid_i=1 and ready_o=1. ready_o = (state==IDLE) and not rst_i.
- Memory outputs are combinational from the request while in IDLE.
  - mem_en_o=1 only for an accepted, aligned request.
  - mem_we_o=0 and mem_wdata_o=0 otherwise.
- Alignment rules: half-word requires addr[0]=0; word requires addr[1:0]=00.
- Misaligned request: no RAM access (mem_en_o=0, mem_we_o=0). The matching misaligned_*_o pulses high in cycle T+1. State stays IDLE.
- Store strobes:
  - byte: we = 0001 shifted left by addr[1:0]; wdata = {4{wdata_i[7:0]}}.
  - half: we = 0011 shifted left by 2*addr[1]; wdata = {2{wdata_i[15:0]}}.
  - word: we = 1111; wdata = wdata_i.
- Stores complete in the accept cycle T. ready_o stays 1, so back-to-back stores are allowed.
- State machine (loads):
  - IDLE -> LOAD_WAIT on an accepted aligned load at cycle T. Latch addr[1:0], size, unsigned and regdest.
  - LOAD_WAIT (T+1): mem_rdata_i is valid. Select the byte/half by the latched offset, extend, and register into rdata_o. Go to LOAD_RESP.
  - LOAD_RESP (T+2): rdata_valid_o=1 for exactly one cycle with regdest_o. ready_o=0. Return to IDLE, so ready_o=1 at T+3.
  - Load-to-result latency is 2 cycles. Load throughput is one load per 3 cycles.
- Extension: signed loads replicate bit 7 (byte) or bit 15 (half) into the upper bits; unsigned loads zero-fill.
- rdata_o holds its value between pulses. It updates only in LOAD_WAIT.
- ctrl_valid_i while ready_o=0 is ignored; the requester must hold it.
- rst_i asserted mid-load: abort the load, go to IDLE, and produce no rdata_valid_o pulse. All outputs take their reset values on the next edge.

Optional Feature:
JEDRO_1_LSU_ERR_ADDR_EN:
- Defined: adds output err_addr_o [ADDR_WIDTH], reset 0. It is loaded with the full addr_i of a misaligned request in the same edge that raises misaligned_*_o, and holds until the next misaligned request.
- Not defined: the port and its register do not exist; misaligned behaviour is otherwise identical.

Test Plan:
- Signed half-word load: RAM[0x40]=0x0000FFFF; lh, addr 0x40, regdest 30 -> at T+2, rdata_valid_o=1, rdata_o=0xFFFFFFFF, regdest_o=30.
- Unsigned loads from the same word:
  - lhu 0x40 -> rdata_o=0x0000FFFF.
  - lbu 0x41 -> rdata_o=0x000000FF.
  - lb 0x41 -> rdata_o=0xFFFFFFFF.
- Upper lanes and positive sign: RAM[0x44]=0x0F0F0000; lh 0x46 -> rdata_o=0x00000F0F; lb 0x47 -> rdata_o=0x0000000F.
- Stores:
  - sh addr 0x102, wdata_i 0x1234ABCD -> same cycle: mem_we_o=1100, mem_addr_o=0x100, mem_wdata_o=0xABCDABCD.
  - sb 0x101 data 0x55 -> mem_we_o=0010.
  - Both stores back-to-back with ready_o staying 1.
- Misaligned accesses:
  - lh 0x41 -> mem_en_o=0; misaligned_load_o pulses at T+1; no rdata_valid_o; err_addr_o=0x41 when JEDRO_1_LSU_ERR_ADDR_EN is defined.
  - sw 0x102 -> misaligned_store_o pulse and mem_we_o=0000.
- Reset mid-load: accept lw, assert rst_i at T+1 -> no rdata_valid_o; ready_o=1 the cycle after rst_i is deasserted; a following lw completes normally.
